// File: rtl/gf180mcu_fd_sc_mcu9t5v0__dlyp_1.sv
// Tapped delay line: DEPTH shift stages, a saturating fill counter and a clamped output tap.
// Optional GF180MCU_FD_SC_DLYP_BYPASS_EN adds a combinational BYP path from I to Z.
module gf180mcu_fd_sc_mcu9t5v0__dlyp_1 #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 8,
  parameter int SELW  = $clog2(DEPTH)
) (
  input  logic             CLK,
  input  logic             RN,
  input  logic [WIDTH-1:0] I,
  input  logic             EN,
  input  logic             FLUSH,
  input  logic [SELW-1:0]  SEL,
`ifdef GF180MCU_FD_SC_DLYP_BYPASS_EN
  input  logic             BYP,
`endif
  output logic [WIDTH-1:0] Z,
  output logic             VLD
);

  localparam int FCW = $clog2(DEPTH + 1);
  localparam logic [FCW-1:0] FC_MAX = FCW'(DEPTH);

  logic [WIDTH-1:0] stage_q [DEPTH];
  logic [WIDTH-1:0] stage_d [DEPTH];
  logic [FCW-1:0]   fc_q;
  logic [FCW-1:0]   fc_d;
  logic [SELW-1:0]  tap;
  logic [WIDTH-1:0] z_tap;
  logic             vld_tap;

  always_comb begin
    if (FLUSH) begin
      stage_d[0] = '0;
    end else if (EN) begin
      stage_d[0] = I;
    end else begin
      stage_d[0] = stage_q[0];
    end
    for (int k = 1; k < DEPTH; k++) begin
      if (FLUSH) begin
        stage_d[k] = '0;
      end else if (EN) begin
        stage_d[k] = stage_q[k-1];
      end else begin
        stage_d[k] = stage_q[k];
      end
    end
  end

  // Counter saturates at DEPTH so VLD can never drop once the line is full.
  always_comb begin
    fc_d = fc_q;
    if (FLUSH) begin
      fc_d = '0;
    end else if (EN && (fc_q != FC_MAX)) begin
      fc_d = fc_q + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      for (int k = 0; k < DEPTH; k++) begin
        stage_q[k] <= '0;
      end
      fc_q <= '0;
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        stage_q[k] <= stage_d[k];
      end
      fc_q <= fc_d;
    end
  end

  // SEL may exceed the last stage when DEPTH is not a power of two.
  always_comb begin
    if (int'(SEL) > DEPTH - 1) begin
      tap = SELW'(DEPTH - 1);
    end else begin
      tap = SEL;
    end
    z_tap   = stage_q[tap];
    vld_tap = (int'(fc_q) > int'(tap));
  end

`ifdef GF180MCU_FD_SC_DLYP_BYPASS_EN
  always_comb begin
    if (BYP) begin
      Z   = I;
      VLD = 1'b1;
    end else begin
      Z   = z_tap;
      VLD = vld_tap;
    end
  end
`else
  always_comb begin
    Z   = z_tap;
    VLD = vld_tap;
  end
`endif

endmodule

// File: doc/gf180mcu_fd_sc_mcu9t5v0__dlyp_1.md
GF180MCU_FD_SC_MCU9T5V0__DLYP_1 -- requirements
Module: gf180mcu_fd_sc_mcu9t5v0__dlyp_1

Interface
REQ-001 Parameter WIDTH, default 1: data bits per stage, legal range 1..32.
REQ-002 Parameter DEPTH, default 8: number of delay stages, legal range 2..64.
REQ-003 Parameter SELW, default clog2(DEPTH): width of the tap-select port.
REQ-004 Port CLK, input, 1 bit: clock; all state updates on its rising edge.
REQ-005 Port RN, input, 1 bit: reset, asynchronous assert, active-low.
REQ-006 Port I, input, WIDTH bits: data into stage 0.
REQ-007 Port EN, input, 1 bit: shift enable.
REQ-008 Port FLUSH, input, 1 bit: synchronous clear of the line.
REQ-009 Port SEL, input, SELW bits: output tap index.
REQ-010 Port Z, output, WIDTH bits: delayed data.
REQ-011 Port VLD, output, 1 bit: asserted when Z holds data shifted in since the last reset or flush.

Function
REQ-012 State: stage[0..DEPTH-1], each WIDTH bits, plus fill counter FC with range 0..DEPTH.
REQ-013 Rising CLK with EN=1 and FLUSH=0: stage[0]<=I, stage[k]<=stage[k-1] for k=1..DEPTH-1, FC<=min(FC+1,DEPTH).
REQ-014 Rising CLK with EN=0 and FLUSH=0: all stages and FC hold.
REQ-015 Rising CLK with FLUSH=1: all stages<=0 and FC<=0; FLUSH wins over EN, and I is discarded that cycle.
REQ-016 Effective tap T=min(SEL,DEPTH-1); an out-of-range SEL clamps to the last stage.
REQ-017 Z=stage[T] combinationally from state and SEL, so latency I->Z is T+1 enabled cycles.
REQ-018 VLD=(FC>T), combinational; a SEL change takes effect on Z and VLD in the same cycle with no state change.
REQ-019 FC saturates at DEPTH and never wraps, so VLD stays 1 for any T once the line is full.
REQ-020 Stages with T below the selected tap continue shifting; only the output mux depends on SEL.
REQ-021 No X propagation from unused stages; every stage has a defined reset value.

Reset
REQ-022 RN=0 forces asynchronously all stages=0, FC=0, Z=0 and VLD=0, regardless of CLK, EN or FLUSH.
REQ-023 RN deassertion is synchronised externally; the first state update happens at the first rising CLK with RN=1.
REQ-024 RN asserted mid-fill discards all contents; the refill after release restarts at FC=0.

Configuration
REQ-025 Macro GF180MCU_FD_SC_DLYP_BYPASS_EN, when defined, adds input BYP (1 bit).
REQ-026 With the macro defined and BYP=1, Z=I and VLD=1 combinationally.
REQ-027 With the macro defined, BYP does not alter stage shifting or FC, and BYP=0 gives exactly the behaviour of REQ-017 and REQ-018.
REQ-028 Without the macro, no BYP port exists and the behaviour is exactly REQ-012 to REQ-024.

Verification
REQ-029 Latency sweep: WIDTH=8, DEPTH=8, SEL=3, EN=1, RN released, I=0xA5 for one cycle then 0 -> Z=0xA5 exactly 4 cycles later; VLD rises on edge 4.
REQ-030 Enable gating: SEL=0, I=1, EN=1 for 2 cycles, then EN=0 for 5 cycles -> Z and FC frozen; VLD stays 1; no shift occurs.
REQ-031 Flush priority: line full (FC=8), FLUSH=1 and EN=1 with I=0xFF -> next cycle all stages=0, FC=0, VLD=0 and Z=0.
REQ-032 Clamp and saturation: DEPTH=6, SEL=7 -> T=5; VLD rises after 6 enabled cycles; after 20 more cycles FC=6 and VLD remains 1.
REQ-033 Async reset mid-operation: RN pulsed low between clock edges while FC=5 -> Z=0 and VLD=0 immediately, without waiting for CLK.
REQ-034 Bypass (macro defined): BYP=1, I toggled with no clock -> Z follows I and VLD=1; BYP dropped -> Z=stage[T] with the shift history unchanged.
